// File: rtl/vram_fetch.sv
// vram_fetch: prefetches six VRAM planes for the next 8-pixel group and
// hands them to the fg/bg pixel registers on every group boundary.
//
// Ports:
//   clk, reset_n        pixel clock, async active-low reset
//   h, v                beam counters (per-cycle, jumps not tracked)
//   vram_req/plane/addr read request, plane 0..5, byte address in plane
//   vram_ack, vram_data read accepted, data valid in the same cycle
//   fg1..fg3, bg1..bg3  planes 0..5 of the group being displayed
//   underrun            sticky: a group was transferred before full fetch
//   underrun_clr        clears underrun (a same-cycle set wins)
module vram_fetch #(
  parameter logic [12:0] BASE     = 13'hEC0,
  parameter logic [8:0]  H_TOTAL  = 9'd256,
  parameter logic [8:0]  V_TOTAL  = 9'd262,
  parameter int          GROUPS   = 24,
  parameter int          V_ACTIVE = 184
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [8:0]  h,
  input  logic [8:0]  v,
  output logic        vram_req,
  output logic [2:0]  vram_plane,
  output logic [12:0] vram_addr,
  input  logic        vram_ack,
  input  logic [7:0]  vram_data,
  output logic [7:0]  fg1,
  output logic [7:0]  fg2,
  output logic [7:0]  fg3,
  output logic [7:0]  bg1,
  output logic [7:0]  bg2,
  output logic [7:0]  bg3,
  output logic        underrun,
  input  logic        underrun_clr
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_e;

  state_e           st_q, st_d;
  logic [2:0]       p_q, p_d;
  logic [12:0]      addr_q, addr_d;
  logic [5:0][7:0]  sh_q, sh_d;
  logic [5:0][7:0]  out_q, out_d;
  logic             und_q, und_d;

  logic [6:0]       grp1;
  logic [8:0]       tgt_line;
  logic [5:0]       tgt_grp;
  logic             tgt_ok;
  logic [12:0]      tgt_addr;
  logic             ack_ok;
  logic             last_ack;

  // Group to fetch next: the following group on this line, or
  // group 0 of the next line when the beam reaches the last slot.
  always_comb begin
    grp1     = {1'b0, h[8:3]} + 7'd1;
    tgt_line = 9'd0;
    tgt_grp  = 6'd0;
    tgt_ok   = 1'b0;
    if (int'(grp1) < GROUPS && int'(v) < V_ACTIVE) begin
      tgt_line = v;
      tgt_grp  = grp1[5:0];
      tgt_ok   = 1'b1;
    end else if (h == H_TOTAL - 9'd8) begin
      tgt_line = (v == V_TOTAL - 9'd1) ? 9'd0 : v + 9'd1;
      tgt_grp  = 6'd0;
      tgt_ok   = int'(tgt_line) < V_ACTIVE;
    end
    tgt_addr = BASE + 13'(tgt_line) * 13'd24 + 13'(tgt_grp);
  end

  always_comb begin
    st_d       = st_q;
    p_d        = p_q;
    addr_d     = addr_q;
    sh_d       = sh_q;
    out_d      = out_q;
    und_d      = und_q;
    vram_req   = 1'b0;
    vram_plane = 3'd0;

    if (st_q == REQ) begin
      vram_req   = 1'b1;
      vram_plane = p_q;
    end

    ack_ok   = (st_q == REQ) && vram_ack;
    last_ack = ack_ok && (p_q == 3'd5);

    if (ack_ok) begin
      sh_d[p_q] = vram_data;
      if (last_ack) st_d = DONE;
      else          p_d  = p_q + 3'd1;
    end

    if (underrun_clr) und_d = 1'b0;

    // Unacked planes are still zero from the clear at fetch start,
    // so a short fetch hands over zeros for the missing planes.
    if (h[2:0] == 3'd7) begin
      out_d = sh_d;
      st_d  = IDLE;
      if (st_q == REQ && !last_ack) und_d = 1'b1;
    end

    if (h[2:0] == 3'd0) begin
      sh_d = '0;
      p_d  = 3'd0;
      if (tgt_ok) begin
        st_d   = REQ;
        addr_d = tgt_addr;
      end else begin
        st_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      p_q    <= 3'd0;
      addr_q <= 13'd0;
      sh_q   <= '0;
      out_q  <= '0;
      und_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      p_q    <= p_d;
      addr_q <= addr_d;
      sh_q   <= sh_d;
      out_q  <= out_d;
      und_q  <= und_d;
    end
  end

  assign vram_addr = addr_q;
  assign fg1       = out_q[0];
  assign fg2       = out_q[1];
  assign fg3       = out_q[2];
  assign bg1       = out_q[3];
  assign bg2       = out_q[4];
  assign bg3       = out_q[5];
  assign underrun  = und_q;

endmodule

// File: tb/tb_vram_fetch.sv
// tb_vram_fetch: directed group-by-group stimulus for vram_fetch
// with hand-computed request, address and pixel-register values.
module tb_vram_fetch;

  logic        clk;
  logic        reset_n;
  logic [8:0]  h;
  logic [8:0]  v;
  logic        vram_req;
  logic [2:0]  vram_plane;
  logic [12:0] vram_addr;
  logic        vram_ack;
  logic [7:0]  vram_data;
  logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
  logic        underrun;
  logic        underrun_clr;

  int n_chk;
  int n_fail;

  vram_fetch dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .h            (h),
    .v            (v),
    .vram_req     (vram_req),
    .vram_plane   (vram_plane),
    .vram_addr    (vram_addr),
    .vram_ack     (vram_ack),
    .vram_data    (vram_data),
    .fg1          (fg1),
    .fg2          (fg2),
    .fg3          (fg3),
    .bg1          (bg1),
    .bg2          (bg2),
    .bg3          (bg3),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [47:0] outs();
    return {fg1, fg2, fg3, bg1, bg2, bg3};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [8:0] hh, input logic [8:0] vv,
                     input logic ack, input logic [7:0] d,
                     input logic clr);
    h            = hh;
    v            = vv;
    vram_ack     = ack;
    vram_data    = d;
    underrun_clr = clr;
  endtask

  // Runs one 8-cycle group; data on cycle i is dbase+i.
  task automatic grp(input logic [8:0] h0, input logic [8:0] vv,
                     input logic [7:0] ackm, input logic [7:0] clrm,
                     input logic [7:0] reqm, input logic [23:0] plm,
                     input logic [12:0] ea, input logic [7:0] dbase);
    for (int i = 0; i < 8; i++) begin
      drv(h0 + 9'(i), vv, ackm[i], dbase + 8'(i), clrm[i]);
      chk("req", 64'(vram_req), 64'(reqm[i]));
      if (reqm[i]) begin
        chk("plane", 64'(vram_plane), 64'(plm[3*i +: 3]));
        chk("addr", 64'(vram_addr), 64'(ea));
      end
      tick();
    end
  endtask

  localparam logic [23:0] PL_FULL =
    {3'd0, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};

  initial begin
    n_chk   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drv(9'd0, 9'd10, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    chk("rst_req", 64'(vram_req), 64'd0);
    chk("rst_plane", 64'(vram_plane), 64'd0);
    chk("rst_addr", 64'(vram_addr), 64'd0);
    chk("rst_outs", 64'(outs()), 64'd0);
    chk("rst_und", 64'(underrun), 64'd0);
    reset_n = 1'b1;

    // Full fetch, ack tied high, line 10 group 1.
    grp(9'd0, 9'd10, 8'hFF, 8'h00, 8'h7E, PL_FULL, 13'hFB1, 8'hA0);
    chk("full_outs", 64'(outs()), 64'hA1A2A3A4A5A6);
    chk("full_und", 64'(underrun), 64'd0);

    // Acks stop after plane 2.
    grp(9'd8, 9'd10, 8'b0000_1110, 8'h00, 8'hFE,
        {3'd3, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0},
        13'hFB2, 8'hB8);
    chk("short_outs", 64'(outs()), 64'hB9BABB000000);
    chk("short_und", 64'(underrun), 64'd1);

    // 3-cycle stall on plane 1, underrun again with clr same cycle.
    grp(9'd16, 9'd10, 8'b0110_0010, 8'b1000_0000, 8'hFE,
        {3'd3, 3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd0, 3'd0},
        13'hFB3, 8'hC0);
    chk("stall_outs", 64'(outs()), 64'hC1C5C6000000);
    chk("set_over_clr", 64'(underrun), 64'd1);

    // Full fetch with a clear mid-group.
    grp(9'd24, 9'd10, 8'hFF, 8'b0000_0010, 8'h7E, PL_FULL,
        13'hFB4, 8'hD0);
    chk("clr_outs", 64'(outs()), 64'hD1D2D3D4D5D6);
    chk("clr_und", 64'(underrun), 64'd0);

    // Last group of the line, then the no-fetch slot after it.
    grp(9'd176, 9'd10, 8'hFF, 8'h00, 8'h7E, PL_FULL,
        13'hFC7, 8'h50);
    chk("g23_outs", 64'(outs()), 64'h515253545556);
    grp(9'd184, 9'd10, 8'hFF, 8'h00, 8'h00, 24'd0, 13'd0, 8'h58);
    chk("nofetch_outs", 64'(outs()), 64'd0);

    // Last line of last active line: next line is inactive.
    grp(9'd248, 9'd183, 8'hFF, 8'h00, 8'h00, 24'd0, 13'd0, 8'h70);
    chk("v183_outs", 64'(outs()), 64'd0);

    // Frame wrap: line 0 group 0.
    grp(9'd248, 9'd261, 8'hFF, 8'h00, 8'h7E, PL_FULL,
        13'hEC0, 8'hE0);
    chk("wrap_outs", 64'(outs()), 64'hE1E2E3E4E5E6);

    // Reset pulse mid-fetch.
    drv(9'd0, 9'd10, 1'b1, 8'hF0, 1'b0);
    tick();
    drv(9'd1, 9'd10, 1'b1, 8'hF1, 1'b0);
    tick();
    drv(9'd2, 9'd10, 1'b1, 8'hF2, 1'b0);
    tick();
    drv(9'd3, 9'd10, 1'b0, 8'hF3, 1'b0);
    chk("pre_rst_req", 64'(vram_req), 64'd1);
    chk("pre_rst_plane", 64'(vram_plane), 64'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("async_req", 64'(vram_req), 64'd0);
    chk("async_outs", 64'(outs()), 64'd0);
    chk("async_addr", 64'(vram_addr), 64'd0);
    #2 reset_n = 1'b1;
    tick();
    for (int i = 4; i < 8; i++) begin
      drv(9'(i), 9'd10, 1'b1, 8'hF0 + 8'(i), 1'b0);
      chk("post_rst_req", 64'(vram_req), 64'd0);
      tick();
    end
    chk("post_rst_outs", 64'(outs()), 64'd0);
    chk("post_rst_und", 64'(underrun), 64'd0);
    grp(9'd8, 9'd10, 8'hFF, 8'h00, 8'h7E, PL_FULL, 13'hFB2, 8'h60);
    chk("resume_outs", 64'(outs()), 64'h616263646566);

    // Inactive line: no requests, acks ignored, zero transfers.
    for (int g = 0; g < 32; g++) begin
      grp(9'(g * 8), 9'd200, 8'hFF, 8'h00, 8'h00, 24'd0, 13'd0, 8'h80);
      chk("blank_outs", 64'(outs()), 64'd0);
    end
    chk("blank_und", 64'(underrun), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_fetch.md
VRAM_FETCH -- requirements
Module: vram_fetch

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  - BASE, 13'hEC0, plane-relative byte address of line 0, group 0.
  - H_TOTAL, 9'd256, pixel clocks per line.
  - V_TOTAL, 9'd262, lines per frame.
  - GROUPS, 24, 8-pixel groups per active line.
  - V_ACTIVE, 184, active lines.
REQ-002 Ports (name, direction, width, meaning), one per line:
  - clk, in, 1, pixel clock; one pixel per cycle.
  - reset_n, in, 1, asynchronous active-low reset.
  - h, in, 9, horizontal counter, 0..H_TOTAL-1, +1 per clk.
  - v, in, 9, vertical counter, 0..V_TOTAL-1.
  - vram_req, out, 1, read request.
  - vram_plane, out, 3, plane select 0..5.
  - vram_addr, out, 13, byte address within plane.
  - vram_ack, in, 1, read accepted; vram_data is valid in the same cycle.
  - vram_data, in, 8, read data.
  - fg1, fg2, fg3, out, 8 each, planes 0,1,2 of the current group.
  - bg1, bg2, bg3, out, 8 each, planes 3,4,5 of the current group.
  - underrun, out, 1, sticky flag: a group was not fully fetched.
  - underrun_clr, in, 1, clears underrun.

Function
REQ-003 Fetch group target, recomputed when h[2:0]==0:
  - If h[8:3]+1 < GROUPS and v < V_ACTIVE: line L=v, group G=h[8:3]+1.
  - Else if h == H_TOTAL-8: line L=v+1 (L=0 when v==V_TOTAL-1), group G=0, valid only if L < V_ACTIVE.
  - Otherwise no fetch; the shadow registers load zero.
REQ-004 vram_addr = BASE + L*24 + G, truncated to 13 bits; held constant for the whole fetch.
REQ-005 FSM states: IDLE, REQ, DONE.
  - h[2:0]==0 with a valid target: enter REQ with plane index p=0 and clear all six shadow bytes; this takes priority over every other state.
  - REQ: drive vram_req=1, vram_plane=p.
  - REQ with vram_ack=1: write shadow[p]=vram_data, p+1; after p=5 go to DONE.
  - REQ with vram_ack=0: hold req, plane and address unchanged.
  - DONE/IDLE: vram_req=0.
REQ-006 At most one ack is consumed per cycle; an ack while vram_req=0 is ignored.
REQ-007 Transfer when h[2:0]==7: shadow[0..5] → fg1,fg2,fg3,bg1,bg2,bg3 in one cycle. New values appear on the edge at which h[2:0] becomes 0.
REQ-008 Transfer while still in REQ:
  - Planes not yet acked transfer as 8'h00.
  - underrun is set.
  - The FSM is forced to IDLE on that edge.
REQ-009 underrun:
  - Set has priority over underrun_clr in the same cycle.
  - Clears only via underrun_clr or reset.
REQ-010 Best case: 6 acks on consecutive cycles complete by h[2:0]==6, one cycle before transfer. Every group has a 7-cycle ack budget.
REQ-011 Counter discontinuities: h jumps are not tracked. Behaviour depends only on the current h/v per cycle.

Reset
REQ-012 While reset_n=0:
  - All outputs are 0 and the FSM is IDLE.
  - All shadow bytes are 0.
  - Any outstanding request is abandoned.
REQ-013 Reset deassertion mid-group: the FSM stays IDLE until the next h[2:0]==0. The next transfer outputs zeros, because the shadow is cleared; underrun is not set.

Verification
REQ-014 Ack tied 1, v=10, h=0..7 → 6 reqs.
  - Planes 0..5 requested at vram_addr = 'hEC0 + 240 + 1 = 'hFB1.
  - fg1..bg3 equal the returned bytes at the edge where h becomes 8.
  - underrun stays 0.
REQ-015 v=V_TOTAL-1, h=H_TOTAL-8 → fetch L=0, G=0, vram_addr='hEC0.
REQ-016 v=200 → no vram_req across the whole line; outputs 0 after each transfer.
REQ-017 Ack withheld after plane 2 → at transfer, fg1..fg3 carry data, bg1..bg3=0, underrun=1.
  - underrun_clr and a new underrun in the same cycle → underrun stays 1.
REQ-018 vram_ack stalls for 3 cycles mid-fetch → vram_plane and vram_addr stable while stalled, and no shadow write.
REQ-019 reset_n pulsed low at h[2:0]==3 during REQ:
  - vram_req drops immediately (asynchronous).
  - fg1..bg3 = 0.
  - Fetching resumes at the next h[2:0]==0.
